mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// Shares one unified single-port memory between the core's instruction-fetch port and its load/store port.
// Sits between rv32i core and memory; one outstanding transaction at a time.
// Latches the winning request so memory-side signals stay stable until accepted.
// Routes the response back to the requester that owns it.
// PARAMETERS
// AW          32  address width (byte address)
// DW          32  data width
// MAX_STREAK  4   consecutive data grants allowed while fetch is pending before fetch is forced; range 1..15
// PORTS
// clk         in   1       clock
// rst         in   1       reset: asynchronous, active-high
// if_req      in   1       fetch request; held until if_gnt
// if_addr     in   AW      fetch address
// if_gnt      out  1       1-cycle pulse: fetch request accepted by memory
// if_rvalid   out  1       1-cycle pulse: if_rdata valid
// if_rdata    out  DW      instruction word
// d_req       in   1       data request; held until d_gnt
// d_we        in   1       1 = store
// d_addr      in   AW      data address
// d_wdata     in   DW      store data (already lane-aligned)
// d_be        in   DW/8    byte enables
// d_gnt       out  1       1-cycle pulse: data request accepted by memory
// d_rvalid    out  1       1-cycle pulse: load data / store ack
// d_rdata     out  DW      load data
// m_req       out  1       memory request
// m_we        out  1       memory write
// m_addr      out  AW      memory address
// m_wdata     out  DW      memory write data
// m_be        out  DW/8    memory byte enables (all ones for fetch)
// m_gnt       in   1       memory accepts m_req this cycle
// m_rvalid    in   1       memory response, for both reads and writes
// m_rdata     in   DW      memory read data
// BEHAVIOUR
// - Reset (async): state=IDLE; streak=0; all outputs 0.
// - FSM IDLE:
//   - Any req present -> pick winner, latch addr/we/wdata/be/owner into regs -> REQ.
//   - Otherwise stay.
// - FSM REQ:
//   - m_req=1; m_* driven from latched regs only, stable until m_gnt.
//   - When m_gnt=1: pulse owner's gnt the same cycle -> RESP.
// - FSM RESP:
//   - m_req=0; wait for m_rvalid.
//   - When m_rvalid=1: owner's rvalid=1 and rdata=m_rdata the same cycle (combinational) -> IDLE.
//   - Non-owner rvalid stays 0.
//   - m_rvalid in IDLE/REQ is ignored.
// - Arbitration:
//   - Data wins over fetch, except when fetch is pending and streak==MAX_STREAK; then fetch wins.
//   - streak increments on each data win while if_req=1.
//   - streak clears on any fetch win, or when if_req=0 at a decision.
//   - streak saturates at MAX_STREAK.
// - Fetch transactions: m_we=0, m_be='1, m_wdata=0.
// - Requester inputs are sampled only in IDLE. Changes while not IDLE have no effect on the transaction in flight.
// - Minimum latency: req at cycle 0 -> m_req cycle 1. With m_gnt at cycle 1, earliest rvalid is cycle 2. One IDLE bubble between transactions.
// - Simultaneous if_req and d_req with streak<MAX_STREAK: data served first; fetch stays pending and is served at the next IDLE decision.
// - Reset mid-transaction: returns to IDLE immediately; no gnt/rvalid pulses. The memory is reset alongside.
// - No timeout: a memory that never responds stalls the arbiter.
// STRUCTURE
// - Package mem_arb_pkg:
//   - typedef enum logic[1:0] {ST_IDLE, ST_REQ, ST_RESP} arb_state_t
//   - typedef enum logic {OWN_IF, OWN_D} arb_owner_t
// - Sub-module mem_arb_pick: combinational priority + starvation override.
//   - Inputs: if_req, d_req, streak.
//   - Outputs: grant_valid, owner, streak_next.
// - Top holds the FSM, latch registers and response routing.
// TESTING
// - Reset: rst pulsed mid-RESP -> all outputs 0 next cycle; state IDLE; a later fetch completes normally.
// - Single fetch: if_addr=0x100, mem returns 0x00500093 two cycles after gnt -> if_gnt pulse; if_rvalid with rdata=0x00500093; d_rvalid stays 0.
// - Store: d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_be=4'b0011 -> m_* match exactly and stay stable while m_gnt is held 0 for 3 cycles; d_rvalid on ack.
// - Collision: if_req and d_req in the same IDLE cycle -> data transaction first, fetch next. Responses never cross ports.
// - Starvation: d_req held high continuously and if_req=1, MAX_STREAK=4 -> exactly 4 data grants, then 1 fetch grant; pattern repeats.
// - Stray response: m_rvalid asserted in IDLE -> no rvalid pulses; next transaction unaffected.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction-fetch / load-store memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RESP} arb_state_t;
  typedef enum logic {OWN_IF, OWN_D} arb_owner_t;

  // Wide enough for the largest allowed MAX_STREAK (15).
  localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: data has priority unless fetch has been
// passed over MAX_STREAK times in a row.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_STREAK = 4
) (
  input  logic                if_req,
  input  logic                d_req,
  input  logic [STREAK_W-1:0] streak,
  output logic                grant_valid,
  output arb_owner_t          owner,
  output logic [STREAK_W-1:0] streak_next
);

  localparam logic [STREAK_W-1:0] MAX_S = STREAK_W'(MAX_STREAK);

  function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] v);
    return (v >= MAX_S) ? MAX_S : v + 1'b1;
  endfunction

  logic fetch_win;

  always_comb begin
    grant_valid = if_req | d_req;
    fetch_win   = if_req & (~d_req | (streak >= MAX_S));
    owner       = fetch_win ? OWN_IF : OWN_D;
    streak_next = streak;
    if (fetch_win) begin
      streak_next = '0;
    end else if (d_req) begin
      // A data win only counts against fetch while fetch is actually waiting.
      streak_next = if_req ? sat_inc(streak) : '0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and load/store ports,
// one outstanding transaction at a time, routing each response to its owner.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            m_req,
  output logic            m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  output logic [DW/8-1:0] m_be,
  input  logic            m_gnt,
  input  logic            m_rvalid,
  input  logic [DW-1:0]   m_rdata
);

  arb_state_t          state, state_n;
  arb_owner_t          owner_q, pick_owner;
  logic [STREAK_W-1:0] streak_q, streak_n;
  logic                grant_valid;
  logic                take;

  logic [AW-1:0]   addr_q;
  logic            we_q;
  logic [DW-1:0]   wdata_q;
  logic [DW/8-1:0] be_q;

  mem_arb_pick #(.MAX_STREAK(MAX_STREAK)) u_pick (
    .if_req      (if_req),
    .d_req       (d_req),
    .streak      (streak_q),
    .grant_valid (grant_valid),
    .owner       (pick_owner),
    .streak_next (streak_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      owner_q  <= OWN_IF;
      streak_q <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        owner_q  <= pick_owner;
        streak_q <= streak_n;
      end
    end
  end

  // Request payload is captured only at the IDLE decision; outputs are gated
  // by state, so these registers need no reset.
  always_ff @(posedge clk) begin
    if (take) begin
      if (pick_owner == OWN_IF) begin
        addr_q  <= if_addr;
        we_q    <= 1'b0;
        wdata_q <= '0;
        be_q    <= '1;
      end else begin
        addr_q  <= d_addr;
        we_q    <= d_we;
        wdata_q <= d_wdata;
        be_q    <= d_be;
      end
    end
  end

  always_comb begin
    state_n   = state;
    take      = 1'b0;
    m_req     = 1'b0;
    m_we      = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    m_be      = '0;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;
    unique case (state)
      ST_IDLE: begin
        if (grant_valid) begin
          take    = 1'b1;
          state_n = ST_REQ;
        end
      end
      ST_REQ: begin
        m_req   = 1'b1;
        m_we    = we_q;
        m_addr  = addr_q;
        m_wdata = wdata_q;
        m_be    = be_q;
        if (m_gnt) begin
          if_gnt  = (owner_q == OWN_IF);
          d_gnt   = (owner_q == OWN_D);
          state_n = ST_RESP;
        end
      end
      ST_RESP: begin
        if (m_rvalid) begin
          if (owner_q == OWN_IF) begin
            if_rvalid = 1'b1;
            if_rdata  = m_rdata;
          end else begin
            d_rvalid = 1'b1;
            d_rdata  = m_rdata;
          end
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level reference model, memory
// responder, directed scenarios and a randomized soak.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int MAX_STREAK = 4;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [BW-1:0] d_be;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          m_req, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [BW-1:0] m_be;
  logic          m_gnt, m_rvalid;
  logic [DW-1:0] m_rdata;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_STREAK(MAX_STREAK)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int tests, fails, cyc;

  // memory responder state and knobs
  int gnt_wait, rsp_delay;
  bit stray_en;
  int pend, age;
  logic [DW-1:0] rsp_q;
  logic [DW-1:0] mem [logic [29:0]];

  // reference model state
  int ph, streak;
  bit md_f;
  logic [AW-1:0] md_addr;
  logic          md_we;
  logic [DW-1:0] md_wdata;
  logic [BW-1:0] md_be;

  // values sampled at the last negedge
  logic s_if_gnt, s_d_gnt, s_if_rv, s_d_rv, s_mreq, s_mwe;
  logic [AW-1:0] s_maddr;
  logic [DW-1:0] s_mwdata;
  logic [BW-1:0] s_mbe;
  int n_if_rv, n_d_rv;
  logic [DW-1:0] cap_if_rd, cap_d_rd;
  bit glog[$];

  function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
    logic [29:0] w;
    w = a[31:2];
    if (mem.exists(w)) return mem[w];
    return {a[15:0], ~a[15:0]} ^ 32'h5a5a_0f0f;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sample_and_check();
    logic [137:0] act, exp;
    logic e_ig, e_dg, e_iv, e_dv, e_mr, e_mw;
    logic [DW-1:0] e_ird, e_drd, e_mwd;
    logic [AW-1:0] e_ma;
    logic [BW-1:0] e_mb;
    e_ig = 0; e_dg = 0; e_iv = 0; e_dv = 0; e_mr = 0; e_mw = 0;
    e_ird = '0; e_drd = '0; e_mwd = '0; e_ma = '0; e_mb = '0;
    s_if_gnt = if_gnt; s_d_gnt = d_gnt; s_if_rv = if_rvalid; s_d_rv = d_rvalid;
    s_mreq = m_req; s_mwe = m_we; s_maddr = m_addr; s_mwdata = m_wdata; s_mbe = m_be;
    if (if_rvalid) begin n_if_rv++; cap_if_rd = if_rdata; end
    if (d_rvalid) begin n_d_rv++; cap_d_rd = d_rdata; end
    if (if_gnt) glog.push_back(1'b1);
    if (d_gnt) glog.push_back(1'b0);
    if (rst) begin
      ph = 0;
      streak = 0;
    end else begin
      case (ph)
        1: begin
          e_mr = 1; e_mw = md_we; e_ma = md_addr; e_mwd = md_wdata; e_mb = md_be;
          if (m_gnt) begin
            e_ig = md_f; e_dg = !md_f; ph = 2;
          end
        end
        2: begin
          if (m_rvalid) begin
            if (md_f) begin e_iv = 1; e_ird = m_rdata; end
            else begin e_dv = 1; e_drd = m_rdata; end
            ph = 0;
          end
        end
        default: begin
          if (if_req || d_req) begin
            md_f = if_req && (!d_req || streak == MAX_STREAK);
            if (md_f) begin
              streak = 0;
              md_addr = if_addr; md_we = 0; md_wdata = '0; md_be = '1;
            end else begin
              streak = if_req ? ((streak < MAX_STREAK) ? streak + 1 : MAX_STREAK) : 0;
              md_addr = d_addr; md_we = d_we; md_wdata = d_wdata; md_be = d_be;
            end
            ph = 1;
          end
        end
      endcase
    end
    act = {if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           m_req, m_we, m_addr, m_wdata, m_be};
    exp = {e_ig, e_iv, e_ird, e_dg, e_dv, e_drd, e_mr, e_mw, e_ma, e_mwd, e_mb};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL cycle %0d outputs: got %h expected %h", cyc, act, exp);
    end
  endtask

  task automatic mem_negedge();
    logic [DW-1:0] cur;
    if (rst) begin
      pend = -1;
      age = 0;
    end else if (m_req && m_gnt) begin
      if (m_we) begin
        cur = mem_rd(m_addr);
        for (int b = 0; b < BW; b++)
          if (m_be[b]) cur[8*b +: 8] = m_wdata[8*b +: 8];
        mem[m_addr[31:2]] = cur;
        rsp_q = $urandom;
      end else begin
        rsp_q = mem_rd(m_addr);
      end
      pend = (rsp_delay < 0) ? int'($urandom_range(0, 3)) : rsp_delay;
      age = 0;
    end else if (m_req) begin
      age++;
    end
  endtask

  task automatic mem_drive();
    if (rst) begin
      m_gnt = 0; m_rvalid = 0; m_rdata = '0;
    end else begin
      if (m_req) m_gnt = (gnt_wait < 0) ? ($urandom_range(0, 2) != 0) : (age >= gnt_wait);
      else m_gnt = stray_en ? 1'($urandom_range(0, 1)) : 1'b0;
      if (pend == 0) begin
        m_rvalid = 1; m_rdata = rsp_q; pend = -1;
      end else if (pend > 0) begin
        m_rvalid = 0; m_rdata = $urandom; pend--;
      end else begin
        m_rvalid = stray_en && ($urandom_range(0, 3) == 0);
        m_rdata = $urandom;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    sample_and_check();
    mem_negedge();
    @(posedge clk);
    #1;
    mem_drive();
  endtask

  function automatic bit ev(input int w);
    case (w)
      0: return s_if_gnt === 1'b1;
      1: return s_d_gnt === 1'b1;
      2: return s_if_rv === 1'b1;
      default: return s_d_rv === 1'b1;
    endcase
  endfunction

  task automatic wait_ev(input int w, input int budget, input string name, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ev(w) && n < budget);
    if (!ev(w)) chk({name, " timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run_reqs(input int budget);
    int outst, n;
    outst = 0;
    n = 0;
    while ((if_req || d_req || outst > 0) && n < budget) begin
      tick();
      n++;
      if (s_if_gnt) begin if_req = 0; outst++; end
      if (s_d_gnt) begin d_req = 0; outst++; end
      if (s_if_rv) outst--;
      if (s_d_rv) outst--;
    end
    if (if_req || d_req || outst > 0) chk("drain timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int n, b_if, b_d, g0;
    logic [9:0] pat;
    tests = 0; fails = 0; cyc = 0;
    rst = 1;
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
    m_gnt = 0; m_rvalid = 0; m_rdata = '0;
    gnt_wait = 0; rsp_delay = 0; stray_en = 0; pend = -1; age = 0; rsp_q = '0;
    ph = 0; streak = 0; md_f = 0; md_addr = '0; md_we = 0; md_wdata = '0; md_be = '0;
    n_if_rv = 0; n_d_rv = 0; cap_if_rd = '0; cap_d_rd = '0;
    mem[30'h40] = 32'h0050_0093;

    repeat (3) tick();
    chk("reset outputs", 64'({s_if_gnt, s_d_gnt, s_if_rv, s_d_rv, s_mreq, s_mwe}), 64'd0);
    rst = 0;
    tick();

    // single fetch with a two-cycle memory response
    rsp_delay = 1;
    b_d = n_d_rv;
    if_addr = 32'h100; if_req = 1;
    wait_ev(0, 10, "fetch gnt", n);
    chk("fetch gnt latency", 64'(n), 64'd2);
    if_req = 0;
    wait_ev(2, 10, "fetch rvalid", n);
    chk("fetch rvalid latency", 64'(n), 64'd2);
    chk("fetch rdata", 64'(cap_if_rd), 64'h0050_0093);
    chk("fetch no d_rvalid", 64'(n_d_rv - b_d), 64'd0);

    // store held off by memory for three cycles, inputs scrambled meanwhile
    rsp_delay = 0; gnt_wait = 3;
    b_if = n_if_rv;
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    tick();
    d_we = 0; d_addr = 32'hFFFF_0000; d_wdata = '0; d_be = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("store m_ctl", 64'({s_mreq, s_mwe, s_mbe}), 64'({1'b1, 1'b1, 4'b0011}));
      chk("store m_addr", 64'(s_maddr), 64'h2000);
      chk("store m_wdata", 64'(s_mwdata), 64'hDEAD_BEEF);
      chk("store d_gnt", 64'(s_d_gnt), 64'(i == 3));
    end
    d_req = 0;
    wait_ev(3, 10, "store ack", n);
    chk("store no if_rvalid", 64'(n_if_rv - b_if), 64'd0);
    gnt_wait = 0;

    // collision: data first, fetch next, each response on its own port
    g0 = glog.size();
    b_if = n_if_rv; b_d = n_d_rv;
    if_req = 1; if_addr = 32'h300;
    d_req = 1; d_we = 0; d_addr = 32'h400; d_be = 4'hF;
    run_reqs(40);
    chk("collision grants", 64'(glog.size() - g0), 64'd2);
    if (glog.size() - g0 == 2) chk("collision order", 64'({glog[g0], glog[g0+1]}), 64'b01);
    chk("collision responses", 64'({n_if_rv - b_if, n_d_rv - b_d}), {32'd1, 32'd1});
    chk("collision d_rdata", 64'(cap_d_rd), 64'(mem_rd(32'h400)));
    chk("collision if_rdata", 64'(cap_if_rd), 64'(mem_rd(32'h300)));

    // starvation guard with both ports continuously requesting
    rsp_delay = -1;
    g0 = glog.size();
    if_req = 1; if_addr = 32'h500; d_req = 1; d_we = 0; d_addr = 32'h600;
    n = 0;
    while (glog.size() - g0 < 10 && n < 300) begin
      tick();
      n++;
      if (s_if_gnt) if_addr = if_addr + 4;
    end
    if_req = 0; d_req = 0;
    repeat (10) tick();
    pat = '0;
    if (glog.size() - g0 >= 10)
      for (int i = 0; i < 10; i++) pat = {pat[8:0], glog[g0+i]};
    chk("starvation pattern", 64'(pat), 64'b00001_00001);

    // reset in the middle of a response wait
    rsp_delay = 6;
    b_if = n_if_rv;
    if_addr = 32'h100; if_req = 1;
    wait_ev(0, 10, "rst fetch gnt", n);
    if_req = 0;
    tick();
    rst = 1;
    #1;
    chk("rst async outputs", 64'({if_gnt, if_rvalid, d_gnt, d_rvalid, m_req}), 64'd0);
    tick();
    chk("rst sampled outputs", 64'({s_if_gnt, s_if_rv, s_d_gnt, s_d_rv, s_mreq}), 64'd0);
    rst = 0;
    repeat (3) tick();
    chk("rst no rvalid", 64'(n_if_rv - b_if), 64'd0);
    rsp_delay = 0;
    if_req = 1;
    run_reqs(20);
    chk("post-rst fetch count", 64'(n_if_rv - b_if), 64'd1);
    chk("post-rst fetch rdata", 64'(cap_if_rd), 64'h0050_0093);

    // stray memory responses while idle, then a normal load
    stray_en = 1;
    b_if = n_if_rv; b_d = n_d_rv;
    repeat (8) tick();
    chk("stray rvalids", 64'({n_if_rv - b_if, n_d_rv - b_d}), 64'd0);
    d_req = 1; d_we = 0; d_addr = 32'h2000; d_be = 4'hF;
    run_reqs(30);
    chk("post-stray load count", 64'(n_d_rv - b_d), 64'd1);
    chk("post-stray load rdata", 64'(cap_d_rd), 64'h7A5A_BEEF);

    // randomized soak
    gnt_wait = -1; rsp_delay = -1;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (s_if_gnt) if_req = 0;
      if (s_d_gnt) d_req = 0;
      if (!if_req && $urandom_range(0, 3) == 0) begin
        if_req = 1;
        if_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      end
      if (!d_req && $urandom_range(0, 2) == 0) begin
        d_req = 1;
        d_we = 1'($urandom_range(0, 1));
        d_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        d_wdata = $urandom;
        d_be = 4'($urandom_range(1, 15));
      end
      if (i == 1000) rst = 1;
      if (i == 1002) rst = 0;
    end
    stray_en = 0;
    run_reqs(50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
